id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 16-bit pipelined CPU.
- Captures both register-file read operands, immediate, PC+2, register IDs and decoded control from decode, and presents them to execute one cycle later.
- Contains load-use hazard detection, which holds IF/ID and inserts a bubble.
- Also handles branch flush, global freeze, and a saturating count of load-use bubbles.

Parameters:
- CTRL_W, 8, width of the decoded control bundle. Bit indices come from the shared package.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_pc2  in  16  PC+2 of the decode instruction.
- id_rs  in  4  source register 1 ID.
- id_rt  in  4  source register 2 ID.
- id_rd  in  4  destination register ID.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt.
- id_src1  in  16  register-file read data 1.
- id_src2  in  16  register-file read data 2.
- id_imm  in  16  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  decoded control.
- flush  in  1  branch/jump taken in EX; squash the decode instruction.
- freeze  in  1  global stall (memory busy); hold all state.
- wb_we  in  1  writeback write enable (used only by the optional feature).
- wb_rd  in  4  writeback destination (used only by the optional feature).
- wb_data  in  16  writeback data (used only by the optional feature).
- lu_stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc2, ex_src1, ex_src2, ex_imm  out  16 each  registered copies.
- ex_rs, ex_rt, ex_rd  out  4 each  registered copies.
- ex_ctrl  out  CTRL_W  registered control; forced to 0 for a bubble.
- lu_count  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (async, immediate): all ex_* outputs, ex_valid and lu_count go to 0. lu_stall = 0 because ex_valid = 0.
- Hazard, combinational:
  - hz = ex_valid & ex_ctrl[CTRL_MEMREAD] & (ex_rd != 0) & id_valid & ((id_rs_used & id_rs == ex_rd) | (id_rt_used & id_rt == ex_rd)).
  - lu_stall = hz & ~flush & ~freeze.
- Per-edge update, highest priority first:
  1. freeze = 1: every register holds; lu_count holds.
  2. flush = 1: bubble. ex_valid = 0, ex_ctrl = 0, data fields don't-care (implementation zeroes them). lu_count unchanged.
  3. hz = 1: bubble, as for flush. lu_count += 1, saturating at all-ones.
  4. Otherwise: load. ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : 0; all data and ID fields load.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs.
- A stalled instruction re-presents at ID next cycle. The bubble clears hz, so it loads on the second edge. At most one bubble per load-use pair.
- rd = 0 never triggers a hazard (R0 is not a true dependency).
- Back-to-back loads each checked independently.
- Simultaneous flush + hz: flush wins, no count, lu_stall = 0.
- Reset asserted mid-stall: outputs clear immediately; lu_stall drops the same cycle.
- An invalid decode slot (id_valid = 0) never stalls and loads as a bubble.

Optional Feature:
- Macro ID_EX_WB_BYPASS_EN.
- When defined, the captured operand is:
  - ex_src1 = (wb_we & wb_rd == id_rs & id_rs != 0) ? wb_data : id_src1.
  - ex_src2 uses the same rule with id_rt.
- The selection uses an address compare, so a write to an unrelated register never corrupts a read.
- When undefined: wb_* are ignored and operands are captured verbatim.

Decomposition:
- Package cpu_pkg holds:
  - CTRL_MEMREAD = 0, CTRL_MEMWRITE = 1, CTRL_REGWRITE = 2, CTRL_BRANCH = 3, CTRL_ALUSRC = 4, CTRL_HALT = 5 (bits 6–7 reserved).
  - REG_ID_W = 4, DATA_W = 16, R0 = 4'd0.
- One natural sub-module, load_use_detect: purely combinational hz logic. It is reused by the IF/ID hold logic.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid = 1 -> all outputs 0 immediately, lu_count = 0.
- Load-use: EX = LW rd=3 (CTRL_MEMREAD); ID = ADD rs=3 used -> lu_stall = 1; next edge ex_valid = 0, lu_count = 1; following edge the ADD loads, ex_rs = 3.
- No hazard on R0 or unused operand: EX LW rd=0, ID rs=0 -> lu_stall = 0. EX LW rd=5, ID rt=5 with id_rt_used = 0 -> lu_stall = 0, ADD loads directly.
- Flush vs hazard: hz and flush both high -> lu_stall = 0, bubble inserted, lu_count unchanged.
- Freeze: freeze = 1 for 3 cycles while ex_src1 = 16'hBEEF and ID inputs change -> ex_* stay constant, lu_stall = 0. After release, the next edge loads ID.
- Saturation and bypass:
  - Preload the count to 16'hFFFE and force 3 hazards -> lu_count ends at 16'hFFFF.
  - With ID_EX_WB_BYPASS_EN: wb_we = 1, wb_rd = 7, wb_data = 16'h1234, id_rs = 7, id_src1 = 0 -> ex_src1 = 16'h1234. With id_rs = 6 -> ex_src1 = id_src1.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 16-bit pipelined CPU: decoded
//               control-bundle bit positions, register/data widths and the
//               hard-wired zero register ID.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Bit positions inside the decoded control bundle (bits 6-7 reserved).
    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_HALT     = 5;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;

    // R0 reads as zero and is never a real dependency.
    localparam logic [REG_ID_W-1:0] R0 = 4'd0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Purely combinational load-use hazard detector. Flags the case
//               where the instruction in EX is a load whose destination is
//               read by the valid instruction currently in decode. Shared
//               with the IF/ID hold logic.
// Ports       : exValid, exMemRead, exRd      - state of the EX slot
//               idValid, idRs, idRt,
//               idRsUsed, idRtUsed            - operand usage of decode
//               hazard                        - load-use dependency present
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import cpu_pkg::*;
(
    input  logic                exValid,
    input  logic                exMemRead,
    input  logic [REG_ID_W-1:0] exRd,
    input  logic                idValid,
    input  logic [REG_ID_W-1:0] idRs,
    input  logic [REG_ID_W-1:0] idRt,
    input  logic                idRsUsed,
    input  logic                idRtUsed,
    output logic                hazard
);

    logic w_rsMatch;
    logic w_rtMatch;

    assign w_rsMatch = idRsUsed & (idRs == exRd);
    assign w_rtMatch = idRtUsed & (idRt == exRd);

    // A load into R0 produces nothing a consumer could depend on.
    assign hazard = exValid & exMemRead & (exRd != R0) & idValid
                  & (w_rsMatch | w_rtMatch);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the 16-bit CPU. Captures operands,
//               immediate, PC+2, register IDs and decoded control from decode
//               and presents them to execute one cycle later. Inserts a
//               bubble on branch flush or load-use hazard, holds everything
//               on freeze, and keeps a saturating count of load-use bubbles.
// Options     : ID_EX_WB_BYPASS_EN - when defined, a same-cycle writeback to
//               rs/rt (non-R0) replaces the register-file read data.
// Ports       : clk, rst (async, active-high)
//               id_*      - decode-stage inputs
//               flush     - squash decode instruction (bubble)
//               freeze    - hold all state
//               wb_*      - writeback port (bypass option only)
//               lu_stall  - combinational hold request for PC and IF/ID
//               ex_*      - registered execute-stage outputs
//               lu_count  - saturating load-use bubble count
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [DATA_W-1:0]   id_pc2,
    input  logic [REG_ID_W-1:0] id_rs,
    input  logic [REG_ID_W-1:0] id_rt,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [DATA_W-1:0]   id_src1,
    input  logic [DATA_W-1:0]   id_src2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic                flush,
    input  logic                freeze,
    input  logic                wb_we,
    input  logic [REG_ID_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                lu_stall,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_pc2,
    output logic [DATA_W-1:0]   ex_src1,
    output logic [DATA_W-1:0]   ex_src2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [REG_ID_W-1:0] ex_rs,
    output logic [REG_ID_W-1:0] ex_rt,
    output logic [REG_ID_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic [CNT_W-1:0]    lu_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic                r_exValid;
    logic [DATA_W-1:0]   r_exPc2;
    logic [DATA_W-1:0]   r_exSrc1;
    logic [DATA_W-1:0]   r_exSrc2;
    logic [DATA_W-1:0]   r_exImm;
    logic [REG_ID_W-1:0] r_exRs;
    logic [REG_ID_W-1:0] r_exRt;
    logic [REG_ID_W-1:0] r_exRd;
    logic [CTRL_W-1:0]   r_exCtrl;
    logic [CNT_W-1:0]    r_luCount;

    logic                w_hz;
    logic [DATA_W-1:0]   w_src1;
    logic [DATA_W-1:0]   w_src2;

    load_use_detect u_detect (
        .exValid   (r_exValid),
        .exMemRead (r_exCtrl[CTRL_MEMREAD]),
        .exRd      (r_exRd),
        .idValid   (id_valid),
        .idRs      (id_rs),
        .idRt      (id_rt),
        .idRsUsed  (id_rs_used),
        .idRtUsed  (id_rt_used),
        .hazard    (w_hz)
    );

    // Flush already squashes the consumer and freeze holds the whole
    // pipe, so neither needs an additional IF/ID hold.
    assign lu_stall = w_hz & ~flush & ~freeze;

`ifdef ID_EX_WB_BYPASS_EN
    // Writeback lands in the register file at the end of this cycle; take
    // the value straight from the writeback port so the read is not stale.
    assign w_src1 = (wb_we && (wb_rd == id_rs) && (id_rs != R0)) ? wb_data : id_src1;
    assign w_src2 = (wb_we && (wb_rd == id_rt) && (id_rt != R0)) ? wb_data : id_src2;
`else
    logic w_unusedWb;
    assign w_unusedWb = ^{wb_we, wb_rd, wb_data};
    assign w_src1     = id_src1;
    assign w_src2     = id_src2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exValid <= 1'b0;
            r_exPc2   <= '0;
            r_exSrc1  <= '0;
            r_exSrc2  <= '0;
            r_exImm   <= '0;
            r_exRs    <= '0;
            r_exRt    <= '0;
            r_exRd    <= '0;
            r_exCtrl  <= '0;
            r_luCount <= '0;
        end else if (!freeze) begin
            if (flush || w_hz) begin
                // Bubble: data fields are don't-care, zeroed for clean traces.
                r_exValid <= 1'b0;
                r_exPc2   <= '0;
                r_exSrc1  <= '0;
                r_exSrc2  <= '0;
                r_exImm   <= '0;
                r_exRs    <= '0;
                r_exRt    <= '0;
                r_exRd    <= '0;
                r_exCtrl  <= '0;
            end else begin
                r_exValid <= id_valid;
                r_exPc2   <= id_pc2;
                r_exSrc1  <= w_src1;
                r_exSrc2  <= w_src2;
                r_exImm   <= id_imm;
                r_exRs    <= id_rs;
                r_exRt    <= id_rt;
                r_exRd    <= id_rd;
                r_exCtrl  <= id_valid ? id_ctrl : '0;
            end
            // Only bubbles caused by the hazard itself are counted.
            if (!flush && w_hz && (r_luCount != c_CNT_MAX)) begin
                r_luCount <= r_luCount + c_CNT_ONE;
            end
        end
    end

    assign ex_valid = r_exValid;
    assign ex_pc2   = r_exPc2;
    assign ex_src1  = r_exSrc1;
    assign ex_src2  = r_exSrc2;
    assign ex_imm   = r_exImm;
    assign ex_rs    = r_exRs;
    assign ex_rt    = r_exRt;
    assign ex_rd    = r_exRd;
    assign ex_ctrl  = r_exCtrl;
    assign lu_count = r_luCount;

endmodule
`default_nettype wire
